// File: rtl/of_pkg.sv
// rtl/of_pkg.sv - shared gradient mode type and output saturation helper
package of_pkg;

    typedef enum logic {
        SOBEL = 1'b0,
        CDIFF = 1'b1
    } grad_mode_e;

    // Clamp a signed value into a grad_width-bit two's-complement range.
    function automatic int sat_grad(input int value, input int grad_width);
        int hi;
        int lo;
        hi = (1 << (grad_width - 1)) - 1;
        lo = -(1 << (grad_width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/line_buffer_3x3.sv
// rtl/line_buffer_3x3.sv - two line RAMs feeding a 3x3 sliding register window
module line_buffer_3x3 #(
    parameter int IMG_WIDTH   = 320,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                en,
    input  logic [$clog2(IMG_WIDTH)-1:0]        col,
    input  logic [PIXEL_WIDTH-1:0]              pixel,
    output logic [2:0][2:0][PIXEL_WIDTH-1:0]    win
);

    // line_a holds the previous row, line_b the row before that; win[row][col], col 2 newest.
    logic [PIXEL_WIDTH-1:0] line_a [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] line_b [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] rd_a;
    logic [PIXEL_WIDTH-1:0] rd_b;

    assign rd_a = line_a[col];
    assign rd_b = line_b[col];

    always_ff @(posedge clk) begin
        if (en) begin
            line_a[col] <= pixel;
            line_b[col] <= rd_a;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= rd_b;
            win[1][2] <= rd_a;
            win[2][2] <= pixel;
        end
    end

endmodule

// File: rtl/gradient_compute_pipe.sv
// rtl/gradient_compute_pipe.sv - Sobel/central-difference spatial and temporal gradient pipeline
module gradient_compute_pipe
    import of_pkg::*;
#(
    parameter int IMG_WIDTH   = 320,
    parameter int IMG_HEIGHT  = 240,
    parameter int PIXEL_WIDTH = 8,
    parameter int GRAD_WIDTH  = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic [PIXEL_WIDTH-1:0]       pixel_curr,
    input  logic [PIXEL_WIDTH-1:0]       pixel_prev,
    input  logic                         mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [GRAD_WIDTH-1:0] grad_x,
    output logic signed [GRAD_WIDTH-1:0] grad_y,
    output logic signed [GRAD_WIDTH-1:0] grad_t,
    output logic                         out_eof
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int SW = PIXEL_WIDTH + 4;

    logic [CW-1:0] col_q, pos_c, nxt_c;
    logic [RW-1:0] row_q, pos_r, nxt_r;
    grad_mode_e    mode_q, mode_px, mode_s1, mode_s2;
    logic          accept;
    logic          vld_s1, vld_s2, eof_s1, eof_s2;
    logic [2:0][2:0][PIXEL_WIDTH-1:0] win_c, win_p;
    logic signed [SW-1:0] avg_w [3][3];
    logic signed [SW-1:0] sx_a, sx_b, sy_a, sy_b, dt;
    logic signed [SW-1:0] sum_x, sum_y, shx, shy;

    function automatic logic signed [SW-1:0] tap_avg(input logic [PIXEL_WIDTH-1:0] c,
                                                     input logic [PIXEL_WIDTH-1:0] p);
        return SW'(({1'b0, c} + {1'b0, p}) >> 1);
    endfunction

    assign in_ready = out_ready || !out_valid;
    assign accept   = in_valid && in_ready;

    // Position of the pixel being offered; an sof pixel is always (0,0).
    always_comb begin
        pos_c   = in_sof ? '0 : col_q;
        pos_r   = in_sof ? '0 : row_q;
        nxt_c   = pos_c + CW'(1);
        nxt_r   = pos_r;
        mode_px = in_sof ? grad_mode_e'(mode) : mode_q;
        if (pos_c == CW'(IMG_WIDTH - 1)) begin
            nxt_c = '0;
            nxt_r = (pos_r == RW'(IMG_HEIGHT - 1)) ? '0 : pos_r + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= SOBEL;
        end else if (accept) begin
            col_q  <= nxt_c;
            row_q  <= nxt_r;
            mode_q <= mode_px;
        end
    end

    line_buffer_3x3 #(.IMG_WIDTH(IMG_WIDTH), .PIXEL_WIDTH(PIXEL_WIDTH)) u_lb_curr (
        .clk   (clk),
        .en    (accept),
        .col   (pos_c),
        .pixel (pixel_curr),
        .win   (win_c)
    );

    line_buffer_3x3 #(.IMG_WIDTH(IMG_WIDTH), .PIXEL_WIDTH(PIXEL_WIDTH)) u_lb_prev (
        .clk   (clk),
        .en    (accept),
        .col   (pos_c),
        .pixel (pixel_prev),
        .win   (win_p)
    );

    // S1: the window registers; a window is a result once its newest pixel is at row>=2, col>=2.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_s1  <= 1'b0;
            eof_s1  <= 1'b0;
            mode_s1 <= SOBEL;
        end else if (in_ready) begin
            vld_s1 <= accept && (pos_r >= RW'(2)) && (pos_c >= CW'(2));
            eof_s1 <= accept && (pos_r == RW'(IMG_HEIGHT - 1)) && (pos_c == CW'(IMG_WIDTH - 1));
            if (accept) mode_s1 <= mode_px;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                avg_w[r][c] = tap_avg(win_c[r][c], win_p[r][c]);
            end
        end
    end

    // S2: partial sums; central difference reuses the doubled-tap slot with no outer columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_s2  <= 1'b0;
            eof_s2  <= 1'b0;
            mode_s2 <= SOBEL;
        end else if (in_ready) begin
            vld_s2  <= vld_s1;
            eof_s2  <= eof_s1;
            mode_s2 <= mode_s1;
            dt      <= $signed({4'b0000, win_p[1][1]}) - $signed({4'b0000, win_c[1][1]});
            if (mode_s1 == SOBEL) begin
                sx_a <= (avg_w[0][2] - avg_w[0][0]) + (avg_w[2][2] - avg_w[2][0]);
                sx_b <= (avg_w[1][2] - avg_w[1][0]) <<< 1;
                sy_a <= (avg_w[2][0] - avg_w[0][0]) + (avg_w[2][2] - avg_w[0][2]);
                sy_b <= (avg_w[2][1] - avg_w[0][1]) <<< 1;
            end else begin
                sx_a <= '0;
                sx_b <= avg_w[1][2] - avg_w[1][0];
                sy_a <= '0;
                sy_b <= avg_w[2][1] - avg_w[0][1];
            end
        end
    end

    always_comb begin
        sum_x = sx_a + sx_b;
        sum_y = sy_a + sy_b;
        shx   = (mode_s2 == SOBEL) ? (sum_x >>> 3) : (sum_x >>> 1);
        shy   = (mode_s2 == SOBEL) ? (sum_y >>> 3) : (sum_y >>> 1);
    end

    // S3: output register with saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            grad_x    <= '0;
            grad_y    <= '0;
            grad_t    <= '0;
        end else if (in_ready) begin
            out_valid <= vld_s2;
            out_eof   <= eof_s2;
            grad_x    <= GRAD_WIDTH'(sat_grad(int'(shx), GRAD_WIDTH));
            grad_y    <= GRAD_WIDTH'(sat_grad(int'(shy), GRAD_WIDTH));
            grad_t    <= GRAD_WIDTH'(sat_grad(int'(dt), GRAD_WIDTH));
        end
    end

endmodule

// File: tb/tb_gradient_compute_pipe.sv
// tb/tb_gradient_compute_pipe.sv - directed self-checking bench for gradient_compute_pipe
module tb_gradient_compute_pipe;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        int x;
        int y;
        int t;
        bit eof;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Small DUTs d1 (GRAD_WIDTH 12) and d2 (GRAD_WIDTH 6) share all inputs.
    logic rst, in_valid, in_sof, mode, out_ready;
    logic [7:0] pc, pp;
    logic rdy1, rdy2, ov1, ov2, e1o, e2o;
    logic signed [11:0] x1, y1, t1;
    logic signed [5:0]  x2, y2, t2;

    logic d0_in_valid, d0_sof, d0_mode, d0_or, d0_rdy, d0_ov, d0_eof;
    logic [7:0] d0_pc, d0_pp;
    logic signed [11:0] d0_x, d0_y, d0_t;

    gradient_compute_pipe #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .GRAD_WIDTH(12)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_sof(in_sof),
        .pixel_curr(pc), .pixel_prev(pp), .mode(mode), .out_valid(ov1), .out_ready(out_ready),
        .grad_x(x1), .grad_y(y1), .grad_t(t1), .out_eof(e1o));

    gradient_compute_pipe #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .GRAD_WIDTH(6)) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_sof(in_sof),
        .pixel_curr(pc), .pixel_prev(pp), .mode(mode), .out_valid(ov2), .out_ready(out_ready),
        .grad_x(x2), .grad_y(y2), .grad_t(t2), .out_eof(e2o));

    gradient_compute_pipe d0 (
        .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(d0_rdy), .in_sof(d0_sof),
        .pixel_curr(d0_pc), .pixel_prev(d0_pp), .mode(d0_mode), .out_valid(d0_ov), .out_ready(d0_or),
        .grad_x(d0_x), .grad_y(d0_y), .grad_t(d0_t), .out_eof(d0_eof));

    ent_t q1[$];
    ent_t q2[$];
    int cnt0 = 0, nz0 = 0, eof0 = 0, eof_at0 = 0;

    always @(negedge clk) begin
        if (ov1 && out_ready) q1.push_back('{int'(x1), int'(y1), int'(t1), e1o});
        if (ov2 && out_ready) q2.push_back('{int'(x2), int'(y2), int'(t2), e2o});
        if (d0_ov && d0_or) begin
            cnt0 = cnt0 + 1;
            if (d0_x != 0 || d0_y != 0 || d0_t != 0) nz0 = nz0 + 1;
            if (d0_eof) begin
                eof0    = eof0 + 1;
                eof_at0 = cnt0;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int fc [H][W];
    int fp [H][W];
    int first_out_cyc, last_acc_cyc, acc18;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int r, input int c, input int which, input bit m, input int gw);
        int a [3][3];
        int v, lim;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                a[i][j] = (fc[r-1+i][c-1+j] + fp[r-1+i][c-1+j]) / 2;
        if (which == 2)
            v = fp[r][c] - fc[r][c];
        else if (which == 0)
            v = m ? ((a[1][2] - a[1][0]) >>> 1)
                  : (((a[0][2] - a[0][0]) + 2 * (a[1][2] - a[1][0]) + (a[2][2] - a[2][0])) >>> 3);
        else
            v = m ? ((a[2][1] - a[0][1]) >>> 1)
                  : (((a[2][0] - a[0][0]) + 2 * (a[2][1] - a[0][1]) + (a[2][2] - a[0][2])) >>> 3);
        lim = 1 << (gw - 1);
        if (v > lim - 1) v = lim - 1;
        if (v < -lim) v = -lim;
        return v;
    endfunction

    task automatic send(input int c, input int p, input bit sof, input bit m);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1; in_sof = sof; pc = 8'(c); pp = 8'(p); mode = m;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (ov1 && first_out_cyc < 0) first_out_cyc = cyc;
            acc = rdy1;
            if (acc) last_acc_cyc = cyc;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0; in_sof = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic do_stall();
        logic [36:0] snap;
        chk("stall_valid", ov1, 1);
        out_ready = 1'b0;
        snap = {ov1, x1, y1, t1};
        repeat (5) begin
            @(negedge clk);
            chk("stall_hold", {ov1, x1, y1, t1}, snap);
            chk("stall_in_ready", rdy1, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    // Non-sof pixels carry the opposite mode; only the sof pixel's mode may take effect.
    task automatic send_frame(input int npix, input bit m, input int stall_at);
        for (int i = 0; i < npix; i++) begin
            send(fc[i/W][i%W], fp[i/W][i%W], i == 0, (i == 0) ? m : !m);
            if (i == 18) acc18 = last_acc_cyc;
            if (i == stall_at) do_stall();
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic fill(input int kind, input int cv, input int pv);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fc[r][c] = (kind == 0) ? 4 * c : (kind == 1) ? cv : int'($urandom_range(0, 255));
                fp[r][c] = (kind == 0) ? 4 * c : (kind == 1) ? pv : int'($urandom_range(0, 255));
            end
    endtask

    task automatic check_const(input string tag, input int ex, input int ey, input int et1, input int et2);
        chk({tag, "_n1"}, q1.size(), 24);
        chk({tag, "_n2"}, q2.size(), 24);
        if (q1.size() == 24 && q2.size() == 24)
            for (int k = 0; k < 24; k++) begin
                chk({tag, "_x"}, q1[k].x, ex);
                chk({tag, "_y"}, q1[k].y, ey);
                chk({tag, "_t1"}, q1[k].t, et1);
                chk({tag, "_t2"}, q2[k].t, et2);
                chk({tag, "_eof"}, q1[k].eof, (k == 23) ? 1 : 0);
            end
        q1.delete();
        q2.delete();
    endtask

    task automatic check_model(input string tag, input bit m, input int off);
        int k;
        chk({tag, "_n1"}, q1.size(), off + 24);
        chk({tag, "_n2"}, q2.size(), off + 24);
        if (q1.size() == off + 24 && q2.size() == off + 24) begin
            for (int j = 0; j < off; j++) chk({tag, "_early_eof"}, q1[j].eof, 0);
            for (int r = 1; r <= H - 2; r++)
                for (int c = 1; c <= W - 2; c++) begin
                    k = off + (r - 1) * (W - 2) + (c - 1);
                    chk({tag, "_x1"}, q1[k].x, model(r, c, 0, m, 12));
                    chk({tag, "_y1"}, q1[k].y, model(r, c, 1, m, 12));
                    chk({tag, "_t1"}, q1[k].t, model(r, c, 2, m, 12));
                    chk({tag, "_x2"}, q2[k].x, model(r, c, 0, m, 6));
                    chk({tag, "_y2"}, q2[k].y, model(r, c, 1, m, 6));
                    chk({tag, "_t2"}, q2[k].t, model(r, c, 2, m, 6));
                    chk({tag, "_eof"}, q1[k].eof, (r == H - 2 && c == W - 2) ? 1 : 0);
                end
        end
        q1.delete();
        q2.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; mode = 1'b0; out_ready = 1'b1; pc = '0; pp = '0;
        d0_in_valid = 1'b0; d0_sof = 1'b0; d0_mode = 1'b0; d0_or = 1'b1; d0_pc = 8'd100; d0_pp = 8'd100;
        first_out_cyc = -1; last_acc_cyc = 0; acc18 = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", ov1, 0);
        chk("rst_eof", e1o, 0);
        chk("rst_gx", x1, 0);
        chk("rst_gy", y1, 0);
        chk("rst_gt", t1, 0);
        chk("rst_valid_d0", d0_ov, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", rdy1, 1);
        chk("rst_in_ready_d0", d0_rdy, 1);
        @(posedge clk); #1;

        fill(0, 0, 0);
        send_frame(W * H, 1'b0, -1);
        chk("latency", first_out_cyc - acc18, 3);
        check_const("ramp_sobel", 4, 0, 0, 0);

        send_frame(W * H, 1'b1, -1);
        check_const("ramp_cdiff", 4, 0, 0, 0);

        fill(1, 50, 60);
        send_frame(W * H, 1'b0, -1);
        check_const("temporal", 0, 0, 10, 10);

        fill(1, 0, 255);
        send_frame(W * H, 1'b0, -1);
        check_const("saturate", 0, 0, 255, 31);

        fill(2, 0, 0);
        send_frame(W * H, 1'b1, 29);
        check_model("stall_cdiff", 1'b1, 0);

        fill(2, 0, 0);
        send_frame(27, 1'b0, -1);
        send_frame(W * H, 1'b0, -1);
        check_model("abandon", 1'b0, 7);

        fill(2, 0, 0);
        send_frame(20, 1'b1, -1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_valid", ov1, 0);
        chk("midrst_gx", x1, 0);
        rst = 1'b0;
        q1.delete();
        q2.delete();
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_stale", ov1, 0);
        end
        @(posedge clk); #1;
        fill(2, 0, 0);
        send_frame(W * H, 1'b0, -1);
        check_model("post_rst", 1'b0, 0);

        for (int i = 0; i < 320 * 240; i++) begin
            d0_in_valid = 1'b1;
            d0_sof = (i == 0);
            d0_mode = (i == 0) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        d0_in_valid = 1'b0;
        d0_sof = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("const_count", cnt0, 318 * 238);
        chk("const_nonzero", nz0, 0);
        chk("const_eof_count", eof0, 1);
        chk("const_eof_pos", eof_at0, 318 * 238);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
